// File: rtl/pc_unit.sv
// Program-counter stage: selects and registers the next fetch address, with RUN/HALT/FAULT control.
// Optional retired-instruction counter enabled by defining PC_TRACE_EN.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_en,
    input  logic [5:0]  op,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam logic [5:0]  OP_HALT = 6'b111111;
    localparam logic [31:0] PC_MAX  = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] target;
    logic [31:0] branch_off;
    logic        target_ok;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    always_comb begin
        target = pc_plus4;
        if (jr)
            target = jr_target;
        else if (jump)
            target = jump_pc;
        else if (branch_taken)
            target = pc_plus4 + branch_off;
    end

    // Wrapped results land above PC_MAX, so one unsigned compare covers them too.
    assign target_ok = (target[1:0] == 2'b00) && (target <= PC_MAX);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (state == S_RUN) begin
            if (op == OP_HALT) begin
                state_nxt = S_HALT;
            end else if (pc_write_en) begin
                if (target_ok)
                    pc_nxt = target;
                else
                    state_nxt = S_FAULT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    assign halted = (state == S_HALT);
    assign fault  = (state == S_FAULT);

`ifdef PC_TRACE_EN
    logic        load;
    logic [31:0] count_q;

    assign load = (state == S_RUN) && (op != OP_HALT) && pc_write_en && target_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (load)
            count_q <= count_q + 32'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule
